// File: rtl/pipeline_pkg.sv
// Shared control-bundle types for the pipelined core's inter-stage registers.
// Callers pack one of these structs into the ctrl payload of pipe_stage_buffer
// and set CTRL_W from the matching width localparam.
package pipeline_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic instr_valid;
    logic pred_taken;
  } if_id_ctrl_t;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [1:0] opa_sel;
    logic [1:0] opb_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [4:0] rd;
    logic       branch;
    logic       jump;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_size;
    logic       reg_wr;
    logic [4:0] rd;
    logic [1:0] wb_sel;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       reg_wr;
    logic [4:0] rd;
    logic [1:0] wb_sel;
  } mem_wb_ctrl_t;

  localparam int unsigned IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
  localparam int unsigned ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int unsigned MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

endpackage

// File: rtl/pipe_stage_buffer_slot.sv
// pipe_slot: one payload register (data + ctrl) with a valid bit.
// Priority: reset > flush > load > clear.
//   clk_i, reset_i : clock, synchronous active-high reset
//   flush_i        : drop entry; ctrl zeroed, data zeroed only if FLUSH_CLR_DATA
//   load_i         : capture data_i/ctrl_i, set valid
//   clear_i        : drop entry, ctrl zeroed, data held
//   valid_o, data_o, ctrl_o : registered slot contents
module pipe_slot
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CTRL_W         = 24,
  parameter bit          FLUSH_CLR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (FLUSH_CLR_DATA) data_d = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: generic inter-stage pipeline register with valid/ready
// handshake, flush, and an optional skid entry so o_ready can be registered.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_flush               : kill held entries and any beat offered this cycle
//   i_valid/o_ready       : upstream handshake, i_data/i_ctrl payload
//   o_valid/i_ready       : downstream handshake, o_data/o_ctrl payload
//   o_occupancy           : held entries (main + skid)
module pipe_stage_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CTRL_W         = 24,
  parameter bit          SKID_EN        = 1'b1,
  parameter bit          FLUSH_CLR_DATA = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy
);

  logic              push, pop;
  logic              main_valid, main_load, main_clear;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic              skid_valid;

  // Flush priority over push is enforced inside each slot.
  assign push = i_valid & o_ready;
  assign pop  = main_valid & i_ready;

  pipe_slot #(
    .DATA_W        (DATA_W),
    .CTRL_W        (CTRL_W),
    .FLUSH_CLR_DATA(FLUSH_CLR_DATA)
  ) u_main (
    .clk_i  (i_clk),
    .reset_i(i_reset),
    .flush_i(i_flush),
    .load_i (main_load),
    .clear_i(main_clear),
    .data_i (main_src_data),
    .ctrl_i (main_src_ctrl),
    .valid_o(main_valid),
    .data_o (o_data),
    .ctrl_o (o_ctrl)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic              skid_load, skid_clear;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      // Main refills when it is empty or being drained; a held skid beat
      // always goes first to keep FIFO order.
      assign main_load     = (~main_valid | pop) & (skid_valid | push);
      assign main_clear    = pop;
      assign main_src_data = skid_valid ? skid_data : i_data;
      assign main_src_ctrl = skid_valid ? skid_ctrl : i_ctrl;
      assign skid_load     = main_valid & ~pop & push;
      assign skid_clear    = skid_valid & (~main_valid | pop);
      assign o_ready       = ~skid_valid;

      pipe_slot #(
        .DATA_W        (DATA_W),
        .CTRL_W        (CTRL_W),
        .FLUSH_CLR_DATA(FLUSH_CLR_DATA)
      ) u_skid (
        .clk_i  (i_clk),
        .reset_i(i_reset),
        .flush_i(i_flush),
        .load_i (skid_load),
        .clear_i(skid_clear),
        .data_i (i_data),
        .ctrl_i (i_ctrl),
        .valid_o(skid_valid),
        .data_o (skid_data),
        .ctrl_o (skid_ctrl)
      );
    end else begin : g_noskid
      assign main_load     = push;
      assign main_clear    = pop;
      assign main_src_data = i_data;
      assign main_src_ctrl = i_ctrl;
      assign skid_valid    = 1'b0;
      assign o_ready       = ~main_valid | i_ready;
    end
  endgenerate

  assign o_valid     = main_valid;
  assign o_occupancy = 2'(main_valid) + 2'(skid_valid);

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 24;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush;
  logic [DW-1:0] idata;
  logic [CW-1:0] ictrl;

  // Instance 1: skid enabled, flush clears data. Instance 0: single register.
  logic          v1, r1, rdy1, ov1;
  logic [DW-1:0] od1;
  logic [CW-1:0] oc1;
  logic [1:0]    occ1;
  logic          v0, r0, rdy0, ov0;
  logic [DW-1:0] od0;
  logic [CW-1:0] oc0;
  logic [1:0]    occ0;

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .FLUSH_CLR_DATA(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(v1), .o_ready(rdy1),
    .i_data(idata), .i_ctrl(ictrl), .o_valid(ov1), .i_ready(r1), .o_data(od1),
    .o_ctrl(oc1), .o_occupancy(occ1));

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .FLUSH_CLR_DATA(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(v0), .o_ready(rdy0),
    .i_data(idata), .i_ctrl(ictrl), .o_valid(ov0), .i_ready(r0), .o_data(od0),
    .o_ctrl(oc0), .o_occupancy(occ0));

  int    vectors = 0;
  int    miscompares = 0;
  bit    chk_en = 1'b0;
  beat_t q1[$];
  beat_t q0[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each instance is a FIFO of accepted-but-not-delivered beats,
  // capacity 2 with registered ready (skid) or 1 with pass-through ready.
  task automatic step(input int k, input logic iv, input logic ir, input logic ordy,
                      input logic ov, input beat_t ob, input logic [1:0] occ);
    int    sz;
    bit    exp_rdy;
    beat_t exp;
    string tag;
    tag     = (k == 1) ? "skid" : "noskid";
    sz      = (k == 1) ? q1.size() : q0.size();
    exp_rdy = (k == 1) ? (sz < 2) : (sz == 0 || ir);
    chk({"occupancy_", tag}, 64'(occ), 64'(sz));
    chk({"o_valid_", tag}, 64'(ov), 64'(sz != 0));
    chk({"o_ready_", tag}, 64'(ordy), 64'(exp_rdy));
    if (!ov) chk({"idle_ctrl_zero_", tag}, 64'(ob.c), 64'd0);
    if (ov && ir && sz != 0) begin
      exp = (k == 1) ? q1.pop_front() : q0.pop_front();
      chk({"beat_", tag}, 64'(ob), 64'(exp));
    end
    if (rst || flush) begin
      if (k == 1) q1.delete(); else q0.delete();
    end else if (iv && exp_rdy) begin
      if (k == 1) q1.push_back('{d: idata, c: ictrl});
      else        q0.push_back('{d: idata, c: ictrl});
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      step(1, v1, r1, rdy1, ov1, '{d: od1, c: oc1}, occ1);
      step(0, v0, r0, rdy0, ov0, '{d: od0, c: oc0}, occ0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
    r1 = 1'b0; v1 = 1'b1;
    idata = a; ictrl = a[CW-1:0] | 24'h1;
    cycle();
    idata = b; ictrl = b[CW-1:0] | 24'h1;
    cycle();
    v1 = 1'b0;
    chk("fill_two_occ", 64'(occ1), 64'd2);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; v1 = 1'b0; r1 = 1'b0; v0 = 1'b0; r0 = 1'b0;
    idata = '0; ictrl = '0;

    // Reset with garbage inputs
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b1; v0 = 1'b1; r1 = 1'($urandom); r0 = 1'($urandom);
      flush = 1'($urandom); idata = $urandom; ictrl = 24'($urandom);
      cycle();
    end
    chk("rst_valid", 64'(ov1), 64'd0);
    chk("rst_ctrl", 64'(oc1), 64'd0);
    chk("rst_data", 64'(od1), 64'd0);
    chk("rst_occ", 64'(occ1), 64'd0);
    chk("rst_data_noskid", 64'(od0), 64'd0);
    rst = 1'b0; flush = 1'b0; v1 = 1'b0; v0 = 1'b0; r1 = 1'b1; r0 = 1'b1;
    #1;
    chk("rst_ready", 64'(rdy1), 64'd1);
    chk("rst_ready_noskid", 64'(rdy0), 64'd1);
    chk_en = 1'b1;

    // Streaming 1..8 with i_ready=1
    for (int i = 1; i <= 8; i++) begin
      v1 = 1'b1; idata = DW'(i); ictrl = CW'(i * 3);
      cycle();
      chk("stream_data", 64'(od1), 64'(i));
      chk("stream_occ", 64'(occ1), 64'd1);
    end
    v1 = 1'b0;
    cycle();
    chk("stream_drained", 64'(occ1), 64'd0);

    // Back-pressure: A, B held, C waits
    r1 = 1'b0; v1 = 1'b1; idata = 32'hA; ictrl = 24'hA0;
    cycle();
    idata = 32'hB; ictrl = 24'hB0;
    cycle();
    chk("bp_occ2", 64'(occ1), 64'd2);
    chk("bp_ready_low", 64'(rdy1), 64'd0);
    idata = 32'hC; ictrl = 24'hC0;
    cycle();
    cycle();
    chk("bp_hold_A", 64'(od1), 64'hA);
    r1 = 1'b1;
    cycle();
    chk("bp_out_B", 64'(od1), 64'hB);
    chk("bp_ready_back", 64'(rdy1), 64'd1);
    cycle();
    v1 = 1'b0;
    chk("bp_out_C", 64'(od1), 64'hC);
    cycle();
    chk("bp_drained", 64'(occ1), 64'd0);

    // Flush with two held while D is offered
    fill_two(32'h1234_5678, 32'h9ABC_DEF0);
    flush = 1'b1; v1 = 1'b1; idata = 32'hD; ictrl = 24'hD0;
    cycle();
    flush = 1'b0; v1 = 1'b0;
    chk("flush_valid", 64'(ov1), 64'd0);
    chk("flush_ctrl", 64'(oc1), 64'd0);
    chk("flush_occ", 64'(occ1), 64'd0);
    chk("flush_data_cleared", 64'(od1), 64'd0);
    r1 = 1'b1;
    cycle();
    cycle();

    // Reset mid-operation together with flush and a valid beat
    fill_two(32'h5555_0001, 32'h5555_0002);
    rst = 1'b1; flush = 1'b1; v1 = 1'b1; idata = 32'hEE; ictrl = 24'hEE;
    cycle();
    rst = 1'b0; flush = 1'b0; v1 = 1'b0; r1 = 1'b1;
    chk("midrst_valid", 64'(ov1), 64'd0);
    chk("midrst_data", 64'(od1), 64'd0);
    chk("midrst_occ", 64'(occ1), 64'd0);
    cycle();
    cycle();

    // Random traffic on both instances against the FIFO model
    for (int i = 0; i < 10000; i++) begin
      rst   = ($urandom_range(0, 999) == 0);
      flush = ($urandom_range(0, 49) == 0);
      v1 = ($urandom_range(0, 3) != 0); r1 = 1'($urandom);
      v0 = ($urandom_range(0, 3) != 0); r0 = 1'($urandom);
      idata = $urandom; ictrl = 24'($urandom);
      cycle();
      if (occ0 > 2'd1) chk("noskid_occ_bound", 64'(occ0), 64'd1);
    end

    rst = 1'b0; flush = 1'b0; v1 = 1'b0; v0 = 1'b0; r1 = 1'b1; r0 = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("final_empty", 64'(occ1), 64'd0);
    chk("final_empty_noskid", 64'(occ0), 64'd0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
